reg_write_port: RTL

REG_WRITE_PORT -- requirements
Module: reg_write_port

---
 rtl/rf_pkg.sv | 17 +
 rtl/wb_fifo.sv | 101 ++++++++++
 rtl/reg_write_port.sv | 104 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write-back path.
//   RF_ADDR_W  default register address width (8 registers)
//   RF_DATA_W  default register data width
//   WB_DEPTH   default write-queue depth
//   wb_entry_t one queued write {addr, data} at the default widths
package rf_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 32;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write queue holding {addr, data} pairs in arrival order.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   push_i, push_addr_i/data_i enqueue one entry at the tail (caller ensures not full)
//   pop_i                      drop the head entry (caller ensures not empty)
//   head_addr_o/head_data_o    head entry, combinational from storage
//   head_ptr_o                 slot index of the head entry
//   count_o, empty_o, full_o   occupancy
//   valid_o, addr_o            per-slot valid flags and addresses for hazard lookup
// Pointers and valid flags are reset; the data/address storage is not.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [PTR_W-1:0]              head_ptr_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  addr_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push_i) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (pop_i) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_mem_q[tail_q] <= push_addr_i;
      data_mem_q[tail_q] <= push_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_o[i] = addr_mem_q[i];
    end
  end

  assign head_addr_o = addr_mem_q[head_q];
  assign head_data_o = data_mem_q[head_q];
  assign head_ptr_o  = head_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == DEPTH_C);
  assign valid_o     = valid_q;

endmodule

// File: rtl/reg_write_port.sv
// reg_write_port: queues register write-backs and drains them into the
// register-file write port one per cycle, in arrival order.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   wb_valid/wb_ready             write-back request handshake
//   wb_addr/wb_data               destination register and value
//   rf_we/rf_waddr/rf_wdata       register-file write strobe, address, data
//   rf_busy                       register-file port unavailable this cycle
//   chk_addr/chk_pending          hazard query: is a write to chk_addr still queued
//   q_count                       number of queued entries
// Optional feature macro: WB_BYPASS_EN -- a request arriving while the queue is
// empty and rf_busy is low is written straight through in the same cycle.
//
// Handshake: a request transfers on a cycle where wb_valid && wb_ready are both 1
// at the rising edge. wb_ready depends only on the current occupancy (not on a
// pop in the same cycle), so the requester must hold wb_valid/addr/data stable
// until it sees wb_ready; nothing is ever dropped.
module reg_write_port
  import rf_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_busy,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_pending,
  output logic [CNT_W-1:0]  q_count
);

  logic                         push;
  logic                         pop;
  logic                         bypass;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [PTR_W-1:0]             head_ptr;
  logic [DEPTH-1:0]             slot_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] slot_addr;
  logic                         pending_raw;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_addr_i (wb_addr),
    .push_data_i (wb_data),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_ptr_o  (head_ptr),
    .count_o     (q_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .valid_o     (slot_valid),
    .addr_o      (slot_addr)
  );

  assign wb_ready = !fifo_full && rst_n;

`ifdef WB_BYPASS_EN
  // Only when nothing is queued can a new write skip ahead without breaking order.
  assign bypass = wb_valid && wb_ready && fifo_empty && !rf_busy;
`else
  assign bypass = 1'b0;
`endif

  assign push = wb_valid && wb_ready && !bypass;
  assign pop  = !fifo_empty && !rf_busy && rst_n;

  assign rf_we    = pop || bypass;
  assign rf_waddr = bypass ? wb_addr : head_addr;
  assign rf_wdata = bypass ? wb_data : head_data;

  // The head slot leaving this cycle no longer counts as pending.
  always_comb begin
    pending_raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slot_addr[i] == chk_addr) &&
          !(pop && (head_ptr == PTR_W'(i)))) begin
        pending_raw = 1'b1;
      end
    end
  end

  assign chk_pending = pending_raw && rst_n;

endmodule
